// File: rtl/serial_pkg.sv
// Shared types and widths for the bit-serial packet transmitter.
package serial_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_STALL   = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Show-ahead byte FIFO feeding the transmitter; a push into a full FIFO is
// honoured only when a pop happens in the same cycle.
module tx_byte_fifo
    import serial_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              ready_o,
    output logic              empty_o
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              ready_q, ready_d;
    logic              empty_q, empty_d;
    logic              do_push_s, do_pop_s;

    // Next-state of pointers, occupancy and the registered full/empty flags.
    always_comb begin
        do_pop_s  = pop_i & ~empty_q;
        do_push_s = push_i & (ready_q | do_pop_s);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != DEPTH_CNT);
        empty_d = (count_d == {(AW+1){1'b0}});
    end

    // Pointer, counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
            ready_q  <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign ready_o   = ready_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/serial_packet_transmitter.sv
// Bit-serial frame transmitter: length byte then payload bytes, LSB first,
// with underrun stalls at byte boundaries and a forced inter-frame gap.
module serial_packet_transmitter
    import serial_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic              tClk,
    input  logic              Rst_n,
    input  logic [BYTE_W-1:0] Din,
    input  logic              Din_Valid,
    output logic              Din_Ready,
    input  logic              Send,
    input  logic [LEN_W-1:0]  Packet_Length,
    output logic              Dout,
    output logic              Dout_Valid,
    output logic              Transmit_flag,
    output logic              Busy,
    output logic              Underrun
);

    localparam int           GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_q, bit_d, next_bit_s;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              flag_q, flag_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic              pop_s, load_s;
    logic [BYTE_W-1:0] fifo_data_s;
    logic              fifo_empty_s;

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (tClk),
        .rst_n       (Rst_n),
        .push_i      (Din_Valid),
        .push_data_i (Din),
        .pop_i       (pop_s),
        .rd_data_o   (fifo_data_s),
        .ready_o     (Din_Ready),
        .empty_o     (fifo_empty_s)
    );

    // Frame sequencing; the output registers hold the bit shown in the next cycle.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        dout_d     = 1'b0;
        valid_d    = 1'b0;
        flag_d     = 1'b0;
        busy_d     = busy_q;
        underrun_d = underrun_q;
        load_s     = 1'b0;
        pop_s      = 1'b0;
        next_bit_s = bit_q + 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (Send) begin
                    state_d    = ST_HEADER;
                    shift_d    = Packet_Length;
                    rem_d      = Packet_Length;
                    bit_d      = 3'd0;
                    dout_d     = Packet_Length[0];
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_HEADER, ST_PAYLOAD: begin
                if (bit_q != 3'd7) begin
                    bit_d   = next_bit_s;
                    dout_d  = shift_q[next_bit_s];
                    valid_d = 1'b1;
                    flag_d  = (next_bit_s == 3'd7);
                end else if (rem_q == {LEN_W{1'b0}}) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LAST;
                end else if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d    = ST_STALL;
                    underrun_d = 1'b1;
                end
            end
            ST_STALL: begin
                if (!fifo_empty_s) begin
                    load_s = 1'b1;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == {GW{1'b0}}) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Next payload byte is popped in the same cycle its bit 0 is registered.
        if (load_s) begin
            state_d = ST_PAYLOAD;
            pop_s   = 1'b1;
            shift_d = fifo_data_s;
            bit_d   = 3'd0;
            dout_d  = fifo_data_s[0];
            valid_d = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
        end else begin
            pop_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge tClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= {BYTE_W{1'b0}};
            bit_q      <= 3'd0;
            rem_q      <= {LEN_W{1'b0}};
            gap_q      <= {GW{1'b0}};
            dout_q     <= 1'b0;
            valid_q    <= 1'b0;
            flag_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            rem_q      <= rem_d;
            gap_q      <= gap_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            flag_q     <= flag_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign Dout          = dout_q;
    assign Dout_Valid    = valid_q;
    assign Transmit_flag = flag_q;
    assign Busy          = busy_q;
    assign Underrun      = underrun_q;

endmodule

// File: tb/tb_serial_packet_transmitter.sv
// Directed and randomized frames checked against a queue-based model of the
// wire format (length byte, then queued payload bytes, LSB first).
module tb_serial_packet_transmitter;

    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic       tClk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] Din = 8'h00;
    logic       Din_Valid = 1'b0;
    logic       Din_Ready;
    logic       Send = 1'b0;
    logic [7:0] Packet_Length = 8'h00;
    logic       Dout, Dout_Valid, Transmit_flag, Busy, Underrun;

    int n_tests = 0;
    int n_fail  = 0;
    byte unsigned model_q[$];

    serial_packet_transmitter #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .tClk          (tClk),
        .Rst_n         (Rst_n),
        .Din           (Din),
        .Din_Valid     (Din_Valid),
        .Din_Ready     (Din_Ready),
        .Send          (Send),
        .Packet_Length (Packet_Length),
        .Dout          (Dout),
        .Dout_Valid    (Dout_Valid),
        .Transmit_flag (Transmit_flag),
        .Busy          (Busy),
        .Underrun      (Underrun)
    );

    always #5 tClk = ~tClk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge tClk);
        check("din_ready", Din_Ready, (model_q.size() < DEPTH));
        Din       = b;
        Din_Valid = 1'b1;
        if (model_q.size() < DEPTH) model_q.push_back(b);
        @(negedge tClk);
        Din_Valid = 1'b0;
    endtask

    task automatic run_frame(input int len, input byte unsigned feed[$], input int repulse,
                             input bit hold_push, input logic [7:0] hold_byte);
        logic bits[$];
        byte unsigned exp_bytes[$];
        int  flags = 0, flag_bad = 0, zero_bad = 0, gap_cnt = 0;
        int  cyc = 0, fi = 0, idle_valid = 0;
        int  total = 8 * (len + 1);
        int  budget = total + 64;
        bit  stall_exp = (model_q.size() < len);
        bit  stall_seen = 1'b0;
        bit  done = 1'b0;
        logic [7:0] got;
        @(negedge tClk);
        Send          = 1'b1;
        Packet_Length = 8'(len);
        @(negedge tClk);
        Send = 1'b0;
        check("latency_valid", Dout_Valid, 1'b1);
        check("underrun_cleared", Underrun, 1'b0);
        check("busy_set", Busy, 1'b1);
        while (!done && cyc < budget) begin
            if (Dout_Valid) begin
                bits.push_back(Dout);
                if (Transmit_flag) begin
                    flags++;
                    if (bits.size() % 8 != 0) flag_bad++;
                end
            end else begin
                if (Dout !== 1'b0) zero_bad++;
                if (Transmit_flag) flag_bad++;
                if (!Busy) begin
                    done = 1'b1;
                end else if (bits.size() < total) begin
                    if (!stall_seen) check("stall_underrun", Underrun, 1'b1);
                    stall_seen = 1'b1;
                end else begin
                    gap_cnt++;
                end
            end
            Send          = (!done && cyc == repulse);
            Packet_Length = 8'($urandom);
            if (done) begin
                Din_Valid = 1'b0;
            end else if (hold_push) begin
                Din_Valid = 1'b1;
                Din       = hold_byte;
            end else if (stall_seen && fi < feed.size()) begin
                Din_Valid = 1'b1;
                Din       = feed[fi];
                model_q.push_back(feed[fi]);
                fi++;
            end else begin
                Din_Valid = 1'b0;
            end
            if (!done) begin
                @(negedge tClk);
                cyc++;
            end
        end
        check("frame_done", done, 1'b1);
        check("valid_bits", bits.size(), total);
        check("flag_pulses", flags, len + 1);
        check("flag_align", flag_bad, 0);
        check("dout_zero_idle", zero_bad, 0);
        check("gap_len", gap_cnt, GAP);
        check("stall_seen", stall_seen, stall_exp);
        check("underrun_sticky", Underrun, stall_exp);
        exp_bytes.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            if (model_q.size() > 0) exp_bytes.push_back(model_q.pop_front());
            else exp_bytes.push_back(8'h00);
        end
        if (hold_push) model_q.push_back(hold_byte);
        for (int k = 0; k <= len; k++) begin
            for (int b = 0; b < 8; b++)
                got[b] = (k * 8 + b < bits.size()) ? bits[k * 8 + b] : 1'bx;
            check("frame_byte", got, exp_bytes[k]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge tClk);
            if (Dout_Valid) idle_valid++;
        end
        check("no_restart", idle_valid, 0);
        check("idle_busy", Busy, 1'b0);
    endtask

    initial begin
        byte unsigned none[$];
        byte unsigned feed[$];
        int n;
        int cyc;
        int len;
        int pre;

        #12;
        check("rst_dout", Dout, 1'b0);
        check("rst_valid", Dout_Valid, 1'b0);
        check("rst_flag", Transmit_flag, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_underrun", Underrun, 1'b0);
        check("rst_ready", Din_Ready, 1'b1);
        @(negedge tClk);
        Rst_n = 1'b1;

        push_byte(8'hA5);
        push_byte(8'h3C);
        run_frame(2, none, -1, 1'b0, 8'h00);

        run_frame(0, none, -1, 1'b0, 8'h00);

        push_byte(8'h81);
        feed = {8'h7E, 8'hC4};
        run_frame(3, feed, -1, 1'b0, 8'h00);

        push_byte(8'h96);
        run_frame(1, none, 3, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        push_byte(8'hEE);
        check("full_ready_low", Din_Ready, 1'b0);
        run_frame(1, none, -1, 1'b1, 8'h5A);
        check("full_after_pushpop", Din_Ready, 1'b0);
        run_frame(DEPTH, none, -1, 1'b0, 8'h00);
        check("drained_ready", Din_Ready, 1'b1);

        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 5));
            pre = int'($urandom_range(0, len));
            feed.delete();
            for (int i = 0; i < pre; i++) push_byte(8'($urandom));
            for (int i = pre; i < len; i++) feed.push_back(8'($urandom));
            run_frame(len, feed, -1, 1'b0, 8'h00);
        end

        push_byte(8'h11);
        push_byte(8'h22);
        @(negedge tClk);
        Send          = 1'b1;
        Packet_Length = 8'd2;
        @(negedge tClk);
        Send = 1'b0;
        n   = 0;
        cyc = 0;
        while (n < 12 && cyc < 40) begin
            if (Dout_Valid) n++;
            @(negedge tClk);
            cyc++;
        end
        check("mid_frame_valid", Dout_Valid, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_valid_drop", Dout_Valid, 1'b0);
        check("async_dout_zero", Dout, 1'b0);
        check("async_busy_drop", Busy, 1'b0);
        check("async_ready", Din_Ready, 1'b1);
        model_q.delete();
        @(negedge tClk);
        Rst_n = 1'b1;
        push_byte(8'hC3);
        run_frame(1, none, -1, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
